fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_queue.sv | 44 ++++
 rtl/fetch_unit.sv | 68 ++++++
 tb/tb_fetch_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-path types, reset default and opcode constants
package cpu_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          FQ_DEPTH         = 2;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry synchronous FIFO of {pc, instr} with flush
module fetch_queue
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);
  fetch_entry_t r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;
  assign w_pop   = i_pop && r_count != 2'd0;
  assign w_push  = i_push && (r_count != 2'd2 || w_pop);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  // storage and pointers; flush overrides any push or pop in the same cycle
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a 2-entry decode queue
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = FQ_DEPTH
) (
  input  logic        clk,
  input  logic        n_rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc
);
  fetch_state_t r_state;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_drop_addr;
  fetch_entry_t w_head;
  fetch_entry_t w_entry;
  logic [1:0]   w_count;
  logic         w_pop;
  logic         w_push;
  logic         w_redirect;
  assign instr_valid = w_count != 2'd0;
  assign instruction = instr_valid ? w_head.instr : '0;
  assign pc          = instr_valid ? w_head.pc : '0;
  assign w_pop       = instr_valid && !stall;
  assign w_redirect  = redirect_valid && r_state != IDLE;
  assign imem_req    = r_state == DROP || (r_state == REQ && (w_count != 2'(QDEPTH) || w_pop));
  assign imem_addr   = r_state == DROP ? r_drop_addr : r_state == REQ ? r_fetch_pc : '0;
  assign w_push      = r_state == REQ && imem_req && imem_ack && !w_redirect;
  assign w_entry     = {r_fetch_pc, imem_rdata};
  fetch_queue u_queue (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_count (w_count)
  );
  // fetch FSM: a redirect with an unacked request parks in DROP until that request drains
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      r_state     <= IDLE;
      r_fetch_pc  <= RESET_PC;
      r_drop_addr <= '0;
    end else begin
      case (r_state)
        IDLE: r_state <= REQ;
        REQ: if (w_redirect && imem_req && !imem_ack) begin
          r_state     <= DROP;
          r_drop_addr <= r_fetch_pc;
        end
        DROP: if (imem_ack) r_state <= REQ;
        default: r_state <= IDLE;
      endcase
      if (w_redirect) r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (w_push) r_fetch_pc <= r_fetch_pc + 32'd4;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a scripted memory responder
module tb_fetch_unit;
  import cpu_pkg::*;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        imem_ack = 1'b0;
  logic        redirect_valid = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic        instr_valid;
  logic [31:0] imem_addr;
  logic [31:0] instruction;
  logic [31:0] pc;
  fetch_entry_t sb[$];
  logic [31:0] exp_fpc = '0;
  logic [31:0] drop_addr = '0;
  bit          drop = 1'b0;
  logic        s_req;
  logic        s_valid;
  logic [31:0] s_pc;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .pc             (pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // one cycle: drive at negedge, sample after settling, answer the request, update the model
  task automatic step(input bit ack_en, input bit stl, input bit rv, input logic [31:0] rpc);
    fetch_entry_t e;
    @(negedge clk);
    stall = stl;
    redirect_valid = rv;
    redirect_pc = rpc;
    imem_ack = 1'b0;
    #1;
    s_req = imem_req;
    s_valid = instr_valid;
    s_pc = pc;
    if (imem_req) chk("imem_addr", imem_addr, drop ? drop_addr : exp_fpc);
    if (ack_en && imem_req) begin
      imem_ack = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end
    if (!instr_valid) chk("empty_out", pc | instruction, 32'h0);
    if (instr_valid && !stl) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pc", pc, e.pc);
        chk("instruction", instruction, e.instr);
      end
    end
    if (imem_ack) begin
      if (drop) drop = 1'b0;
      else if (!rv) begin
        sb.push_back({exp_fpc, mem_word(exp_fpc)});
        exp_fpc = exp_fpc + 32'd4;
      end
    end
    if (rv) begin
      if (imem_req && !imem_ack && !drop) begin
        drop = 1'b1;
        drop_addr = exp_fpc;
      end
      exp_fpc = {rpc[31:2], 2'b00};
      sb.delete();
    end
  endtask

  // async reset with a stray ack held through reset and the IDLE cycle
  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pc", pc, 32'h0);
    sb.delete();
    exp_fpc = 32'h0;
    drop = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    #1;
    chk("idle_req", 32'(imem_req), 32'd0);
  endtask

  initial begin
    do_reset();
    // back-to-back same-cycle acks
    step(1, 0, 0, 0);
    chk("first_req", 32'(s_req), 32'd1);
    chk("idle_ack_ignored", 32'(s_valid), 32'd0);
    step(1, 0, 0, 0);
    chk("latency", 32'(s_valid), 32'd1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // late ack: request held for three cycles
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("late_req_held", 32'(s_req), 32'd1);
    end
    step(1, 0, 0, 0);
    chk("late_not_yet", 32'(s_valid), 32'd0);
    step(0, 0, 0, 0);
    chk("late_valid", 32'(s_valid), 32'd1);
    // long stall fills the queue
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    chk("stall_req", 32'(s_req), 32'd0);
    chk("stall_valid", 32'(s_valid), 32'd1);
    chk("stall_head", s_pc, 32'h0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // redirect with request to 0x8 outstanding
    step(0, 0, 1, 32'h103);
    step(0, 0, 0, 0);
    chk("drop_req", 32'(s_req), 32'd1);
    step(1, 0, 0, 0);
    chk("drop_valid", 32'(s_valid), 32'd0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("redir_pc", s_pc, 32'h100);
    // redirect coinciding with ack and pop
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 32'h200);
    step(0, 0, 0, 0);
    chk("flush_valid", 32'(s_valid), 32'd0);
    chk("flush_req", 32'(s_req), 32'd1);
    // reset mid-request
    do_reset();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("post_rst_pc", s_pc, 32'h0);
    // redirect, re-redirect while dropping, then wrap past 2^32
    step(0, 0, 1, 32'h300);
    step(0, 0, 1, 32'hFFFF_FFFE);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("wrap_pc", s_pc, 32'h0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
